// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a line-wide memory.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller #(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned INDEX_W    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [31:0]             cpu_addr_i,
    input  logic [31:0]             cpu_data_i,
    output logic [31:0]             cpu_data_o,
    output logic                    cpu_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_data_o,
    input  logic [LINE_BYTES*8-1:0] mem_data_i,
    input  logic                    mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o
`endif
);

    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned TAG_W  = 32 - OFF_W - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    line_q [NUM_LINES];

    logic [LINE_W-1:0]    line_d;
    logic                 line_we;
    logic                 tag_we;

    logic [INDEX_W-1:0]   req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [2:0]           word_sel;
    logic [LINE_W-1:0]    cur_line;
    logic [WORD_W-1:0]    cur_word;
    logic                 hit_c;
    logic                 miss_c;
    logic                 unused_addr_bits;

    assign req_idx          = cpu_addr_i[OFF_W +: INDEX_W];
    assign req_tag          = cpu_addr_i[31 -: TAG_W];
    assign word_sel         = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign cur_line         = line_q[req_idx];
    assign cur_word         = cur_line[{word_sel, 5'b0} +: WORD_W];

    // Lookup is only meaningful while idle; stalled requests are held by the pipeline.
    assign hit_c  = (state_q == S_IDLE) && cpu_req_i && valid_q[req_idx]
                    && (tag_q[req_idx] == req_tag);
    assign miss_c = (state_q == S_IDLE) && cpu_req_i && !hit_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage survive reset; validity alone decides hits.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            line_q[req_idx] <= line_d;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        line_d      = cur_line;
        line_we     = 1'b0;
        tag_we      = 1'b0;
        cpu_data_o  = '0;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (hit_c) begin
                    cpu_data_o = cur_word;
                    if (cpu_we_i) begin
                        line_d[{word_sel, 5'b0} +: WORD_W] = cpu_data_i;
                        line_we          = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end
                end else if (miss_c) begin
                    cpu_stall_o = 1'b1;
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[req_idx], req_idx, 5'b0};
                mem_data_o  = cur_line;
                if (mem_ack_i) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {req_tag, req_idx, 5'b0};
                if (mem_ack_i) begin
                    line_d           = mem_data_i;
                    line_we          = 1'b1;
                    tag_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        replay_q, replay_d;

    // The replay hit after a refill belongs to the miss, so it is not counted as a hit.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        replay_d     = (state_q == S_ALLOCATE) && mem_ack_i;
        if (hit_c && !replay_q) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_c) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            replay_q     <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            replay_q     <= replay_d;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: stimulus queues expected loads and memory transactions,
// a negedge monitor pops and compares them; a behavioural line memory answers with a programmable delay.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;
`endif

    dcache_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o (hit_count_o),
        .miss_count_o(miss_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_exp_t;

    mem_exp_t     mem_q[$];
    logic [31:0]  cpu_q[$];
    logic [255:0] mem_model [logic [31:0]];

    int vectors     = 0;
    int miscompares = 0;
    int mem_delay   = 0;
    int wait_cnt    = 0;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Untouched lines hold the byte address of each word.
    function automatic logic [255:0] get_line(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(i * 4);
        return l;
    endfunction

    // Line memory: acks after mem_delay cycles of request; drops a request that goes away.
    initial begin
        logic ack_prev;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            ack_prev  = mem_ack_i;
            mem_ack_i = 1'b0;
            if (!mem_req_o) begin
                wait_cnt = 0;
            end else begin
                if (ack_prev) wait_cnt = 0;
                if (wait_cnt == mem_delay) begin
                    if (mem_we_o) mem_model[mem_addr_o] = mem_data_o;
                    else          mem_data_i = get_line(mem_addr_o);
                    mem_ack_i = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk_i) begin
        mem_exp_t e;
        if (!rst_i) begin
            if (mem_req_o) check("stall_during_mem", 256'(cpu_stall_o), 256'(1'b1));
            if (mem_req_o && prev_req && !prev_ack)
                check("mem_addr_stable", 256'(mem_addr_o), 256'(prev_addr));
            if (mem_req_o && mem_ack_i) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_txn", 256'(mem_addr_o), 256'(32'hFFFF_FFFF));
                end else begin
                    e = mem_q.pop_front();
                    check("mem_we", 256'(mem_we_o), 256'(e.we));
                    check("mem_addr", 256'(mem_addr_o), 256'(e.addr));
                    check("mem_data", mem_data_o, e.data);
                end
            end
            if (cpu_req_i && !cpu_stall_o && !cpu_we_i) begin
                if (cpu_q.size() == 0) check("unexpected_load", 256'(cpu_data_o), 256'(32'hFFFF_FFFF));
                else                   check("load_data", 256'(cpu_data_o), 256'(cpu_q.pop_front()));
            end
            if (!cpu_req_i && !mem_req_o) begin
                check("idle_stall", 256'(cpu_stall_o), 256'(1'b0));
                check("idle_data", 256'(cpu_data_o), 256'(32'h0));
            end
        end
        prev_req  = mem_req_o;
        prev_ack  = mem_ack_i;
        prev_addr = mem_addr_o;
    end

    // Present one access from posedge+1, count stall cycles, return at the posedge+1 after completion.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input int exp_stalls);
        int  stalls = 0;
        bit  done   = 0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        if (!we) cpu_q.push_back(exp_data);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) done = 1;
            else              stalls++;
        end
        if (!done) check("access_timeout", 256'(0), 256'(1));
        check("stall_cycles", 256'(stalls), 256'(exp_stalls));
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", 256'(cpu_stall_o), 256'(1'b0));
        check("rst_mem_req", 256'(mem_req_o), 256'(1'b0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(32'h0));
        check("rst_cpu_data", 256'(cpu_data_o), 256'(32'h0));
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", 256'(hit_count_o), 256'(32'd0));
        check("rst_miss_count", 256'(miss_count_o), 256'(32'd0));
`endif
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        logic [255:0] line40;
        logic [255:0] wb40;
        cpu_req_i  = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        rst_i      = 1'b1;

        for (int i = 0; i < 8; i++) line40[i*32 +: 32] = 32'h4000_0000 + 32'(i);
        line40[31:0]      = 32'hDEAD_BEEF;
        mem_model[32'h40] = line40;
        wb40              = line40;
        wb40[63:32]       = 32'h1234_5678;

        do_reset();

        // Cold load miss: stall, clean refill, replay hit.
        mem_q.push_back('{we: 1'b0, addr: 32'h40, data: '0});
        access(1'b0, 32'h40, '0, 32'hDEAD_BEEF, 2);
`ifdef DCACHE_STATS_EN
        check("miss_after_refill", 256'(miss_count_o), 256'(32'd1));
        check("hit_after_refill", 256'(hit_count_o), 256'(32'd0));
`endif
        // Store hit, then load hit of the stored word.
        access(1'b1, 32'h44, 32'h1234_5678, '0, 0);
`ifdef DCACHE_STATS_EN
        check("hit_after_store", 256'(hit_count_o), 256'(32'd1));
`endif
        access(1'b0, 32'h44, '0, 32'h1234_5678, 0);
        idle(1);

        // Same-index conflict with dirty victim: write-back then refill.
        mem_q.push_back('{we: 1'b1, addr: 32'h40, data: wb40});
        mem_q.push_back('{we: 1'b0, addr: 32'h240, data: '0});
        access(1'b0, 32'h240, '0, 32'h240, 3);
        check("wb_stored", mem_model[32'h40], wb40);
        idle(1);

        // Slow memory: ten wait cycles before ack.
        mem_delay = 10;
        mem_q.push_back('{we: 1'b0, addr: 32'h300, data: '0});
        access(1'b0, 32'h308, '0, 32'h308, 12);
        idle(1);

        // Reset during ALLOCATE abandons the refill.
        mem_delay  = 5;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h500;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_mem_req", 256'(mem_req_o), 256'(1'b0));
        check("abort_stall", 256'(cpu_stall_o), 256'(1'b0));
        @(posedge clk_i);
        #1;
        mem_delay = 0;
        mem_q.push_back('{we: 1'b0, addr: 32'h500, data: '0});
        access(1'b0, 32'h500, '0, 32'h500, 2);
        mem_q.push_back('{we: 1'b0, addr: 32'h240, data: '0});
        access(1'b0, 32'h240, '0, 32'h240, 2);
        idle(1);

        // Back-to-back loads within one line after a single refill.
        do_reset();
        mem_q.push_back('{we: 1'b0, addr: 32'h80, data: '0});
        access(1'b0, 32'h80, '0, 32'h80, 2);
        access(1'b0, 32'h84, '0, 32'h84, 0);
        access(1'b0, 32'h9C, '0, 32'h9C, 0);
`ifdef DCACHE_STATS_EN
        check("b2b_miss_count", 256'(miss_count_o), 256'(32'd1));
        check("b2b_hit_count", 256'(hit_count_o), 256'(32'd2));
`endif
        idle(3);

        check("cpu_queue_drained", 256'(cpu_q.size()), 256'(0));
        check("mem_queue_drained", 256'(mem_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache placed between the EXMEM stage outputs and a slow line-wide data memory.
- Hits complete in the same cycle as the MEM-stage access.
- Misses raise a stall that freezes the whole pipeline while the controller writes back a dirty victim and refills the line.
- Replaces direct wiring of MemRead/MemWrite/ALU address to the flat data memory.

Parameters:
- NUM_LINES, 16, number of cache lines (power of two, at least 2).
- LINE_BYTES, 32, bytes per line; fixed 256-bit line, 8 words.
- INDEX_W, 4, log2(NUM_LINES).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset.
- cpu_req_i  in  1  access request (EXMEM MemRead | MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address (EXMEM ALU result).
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  freeze PC/IFID/IDEX/EXMEM/MEMWB.
- mem_req_o  out  1  memory request, level.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned memory address, bits [4:0] = 0.
- mem_data_o  out  256  victim line for write-back.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  one-cycle completion pulse.

Interface rules: one clock, clk_i; reset rst_i is synchronous and active-high.

Behaviour:
- Address split:
  - word select = addr[4:2]; addr[1:0] ignored.
  - index = addr[4+INDEX_W:5].
  - tag = addr[31:5+INDEX_W] (23 bits at default).
- Storage per line: valid, dirty, tag, 256-bit data; register arrays internal to the block.
- hit = cpu_req_i & valid[index] & (tag[index] == addr tag), evaluated in IDLE only.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Read hit: cpu_data_o = selected word combinationally; cpu_stall_o = 0; zero added latency.
  - Write hit: selected word replaced by cpu_data_i at the clock edge; dirty[index] set; cpu_stall_o = 0.
  - Miss, victim valid & dirty: cpu_stall_o = 1 combinationally the same cycle; next state WRITEBACK.
  - Miss, otherwise: cpu_stall_o = 1 combinationally the same cycle; next state ALLOCATE.
  - cpu_req_i = 0: no state change, cpu_stall_o = 0, cpu_data_o = 0.
- WRITEBACK:
  - Outputs: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
  - Remains until mem_ack_i, then goes to ALLOCATE. Dirty is not cleared here.
- ALLOCATE:
  - Outputs: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i: line <= mem_data_i, tag updated, valid = 1, dirty = 0; next state IDLE.
- Replay: in the IDLE cycle after ALLOCATE the held request hits and completes as a normal hit. A store merges at that edge and sets dirty. Miss penalty is at least 2 cycles clean, at least 3 cycles dirty, plus memory wait.
- cpu_stall_o is 1 throughout WRITEBACK and ALLOCATE.
- The pipeline holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while stalled; the controller does not re-latch them.
- mem_req_o is held high until ack. mem_ack_i is ignored in IDLE.
- An ack arriving in the same cycle as entry into a state is not possible: req is registered-state-driven, so the earliest ack is in the first cycle of WRITEBACK/ALLOCATE, and it is accepted then.
- Outside WRITEBACK: mem_we_o = 0 and mem_data_o = 0. mem_addr_o = 0 in IDLE.
- Reset values: state IDLE, all valid and dirty = 0, mem_req_o = 0.
- Reset mid-miss: the transaction is aborted at the edge and mem_req_o is 0 the next cycle; the memory model must drop an abandoned request. Data and tag arrays are not cleared.
- Same-index conflict (load of tag B after store to tag A): victim A written back first, then B fetched.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, adds ports:
  - hit_count_o  out  32  number of hits.
  - miss_count_o  out  32  number of misses.
  - Both reset to 0 and wrap modulo 2^32.
- Counting rules:
  - miss_count_o increments on each IDLE cycle that leaves IDLE due to a miss.
  - hit_count_o increments on each IDLE hit cycle, except the replay cycle immediately following ALLOCATE. An internal replay flag is set on ALLOCATE->IDLE and cleared after one cycle.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then load 0x0000_0040 -> stall same cycle. ALLOCATE with mem_addr_o = 0x40; ack with a line whose word 0 is 0xDEADBEEF. Next cycle: stall = 0, cpu_data_o = 0xDEADBEEF; miss_count = 1, hit_count = 0.
- Store 0x12345678 to 0x44 after the above -> no stall. A following load of 0x44 returns 0x12345678; hit_count = 1.
- Load 0x0000_0240 (same index 2, different tag) with line 2 dirty -> WRITEBACK with mem_addr_o = 0x40, mem_we_o = 1, mem_data_o word 1 = 0x12345678. Then ALLOCATE at 0x240, then hit.
- Memory ack delayed 10 cycles -> mem_req_o and mem_addr_o stable; cpu_stall_o = 1 for all cycles until the replay cycle.
- rst_i asserted during ALLOCATE -> next cycle state IDLE, mem_req_o = 0, stall = 0. Re-access of the same address misses again (valid cleared).
- Back-to-back loads 0x80, 0x84, 0x9C after one refill -> one miss, then two single-cycle hits with no stall; miss_count = 1, hit_count = 2.
